led_scan_driver: RTL and testbench

Consumer of the divided LED clock `clkLeds` produced by the ripple frequency divider in the irrigation-system display path. Synchronizes that slow clock into the system `clk` domain as a one-cycle scan tick. Uses the tick to time-multiplex a bank of 7-segment digits (active-low anodes and segments). Adds an alarm blink mode for irrigation faults.

---
 rtl/led_scan_driver.sv | 122 ++++++++++++
 tb/tb_led_scan_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_driver.sv
// Multiplexed 7-segment scan driver paced by the divided LED clock.
// clkLeds is sampled as data; each rising edge yields one clk-wide scan tick.
module led_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int BLINK_TICKS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clkLeds,
  input  logic                    enable,
  input  logic                    alarm,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_TICKS > 0) ? $clog2(2 * BLINK_TICKS) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(2 * BLINK_TICKS - 1);
  localparam logic [BW-1:0] BCNT_HALF = BW'(BLINK_TICKS);

  logic          s0, s1, prev;
  logic [IW-1:0] idx;
  logic [BW-1:0] bcnt;

  logic                  blank;
  logic [3:0]            code;
  logic                  dp_sel;
  logic [NUM_DIGITS-1:0] onehot;

  function automatic logic [6:0] decode(input logic [3:0] hex);
    case (hex)
      4'h0:    decode = 7'h40;
      4'h1:    decode = 7'h79;
      4'h2:    decode = 7'h24;
      4'h3:    decode = 7'h30;
      4'h4:    decode = 7'h19;
      4'h5:    decode = 7'h12;
      4'h6:    decode = 7'h02;
      4'h7:    decode = 7'h78;
      4'h8:    decode = 7'h00;
      4'h9:    decode = 7'h10;
      4'hA:    decode = 7'h08;
      4'hB:    decode = 7'h03;
      4'hC:    decode = 7'h46;
      4'hD:    decode = 7'h21;
      4'hE:    decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // Sync chain resets high so a level already high at release gives no tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0   <= 1'b1;
      s1   <= 1'b1;
      prev <= 1'b1;
      tick <= 1'b0;
    end else begin
      s0   <= clkLeds;
      s1   <= s0;
      prev <= s1;
      tick <= s1 & ~prev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (!enable) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
    end else if (!alarm || !enable) begin
      bcnt <= '0;
    end else if (tick) begin
      bcnt <= (bcnt == BCNT_LAST) ? '0 : bcnt + 1'b1;
    end
  end

  always_comb begin
    blank  = alarm & (bcnt >= BCNT_HALF);
    code   = 4'h0;
    dp_sel = 1'b0;
    onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        code      = digits[4*i +: 4];
        dp_sel    = dp[i];
        onehot[i] = 1'b1;
      end
    end
  end

  // Outputs follow digits/dp every edge so data changes need no tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an   <= '1;
      seg  <= 7'h7F;
      dp_n <= 1'b1;
    end else if (!enable || blank) begin
      an   <= '1;
      seg  <= 7'h7F;
      dp_n <= 1'b1;
    end else begin
      an   <= ~onehot;
      seg  <= decode(code);
      dp_n <= ~dp_sel;
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver with 4 digits and an 8-tick blink.
module tb_led_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clkLeds;
  logic        enable;
  logic        alarm;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        tick;

  int n_checks = 0;
  int n_fail   = 0;

  led_scan_driver #(.NUM_DIGITS(4), .BLINK_TICKS(8)) dut (
    .clk(clk), .rst_n(rst_n), .clkLeds(clkLeds), .enable(enable),
    .alarm(alarm), .digits(digits), .dp(dp), .an(an), .seg(seg),
    .dp_n(dp_n), .tick(tick)
  );

  always #5 clk = ~clk;

  // One clkLeds period: 20 clk low then 20 clk high; captures what the
  // outputs look like at edges 3, 4 and 5 after the rising level is sampled.
  task automatic pulse(output logic low_tick, output logic t3,
                       output logic [3:0] an4, output logic [3:0] an5,
                       output logic [6:0] seg5, output logic dpn5);
    low_tick = 1'b0;
    clkLeds  = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tick) low_tick = 1'b1;
    end
    clkLeds = 1'b1;
    repeat (3) @(posedge clk);
    #1 t3 = tick;
    @(posedge clk); #1 an4 = an;
    @(posedge clk); #1;
    an5 = an; seg5 = seg; dpn5 = dp_n;
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic saw;
    rst_n = 1'b1; clkLeds = 1'b1; enable = 1'b1; alarm = 1'b0;
    digits = 16'h3210; dp = 4'b0000;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (an !== 4'hF)   begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h expected 7f", seg); end
    n_checks++; if (dp_n !== 1'b1) begin n_fail++; $display("FAIL reset_dpn: got %b expected 1", dp_n); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", tick); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL release_an: got %b expected 1110", an); end
    n_checks++; if (seg !== 7'h40)  begin n_fail++; $display("FAIL release_seg: got %h expected 40", seg); end
    saw = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (tick) saw = 1'b1; end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL release_no_tick: got %b expected 0", saw); end
  endtask

  task automatic test_scan;
    logic [3:0] ea [4];
    logic [6:0] es [4];
    logic [3:0] prev_an, an4, an5;
    logic [6:0] seg5;
    logic       lt, t3, dpn5;
    ea = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    es = '{7'h79, 7'h24, 7'h30, 7'h40};
    prev_an = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      pulse(lt, t3, an4, an5, seg5, dpn5);
      n_checks++; if (lt !== 1'b0)      begin n_fail++; $display("FAIL scan_fall_tick[%0d]: got %b expected 0", i, lt); end
      n_checks++; if (t3 !== 1'b1)      begin n_fail++; $display("FAIL scan_tick_e3[%0d]: got %b expected 1", i, t3); end
      n_checks++; if (an4 !== prev_an)  begin n_fail++; $display("FAIL scan_an_e4[%0d]: got %b expected %b", i, an4, prev_an); end
      n_checks++; if (an5 !== ea[i])    begin n_fail++; $display("FAIL scan_an_e5[%0d]: got %b expected %b", i, an5, ea[i]); end
      n_checks++; if (seg5 !== es[i])   begin n_fail++; $display("FAIL scan_seg[%0d]: got %h expected %h", i, seg5, es[i]); end
      prev_an = ea[i];
    end
  endtask

  task automatic test_digits_dp;
    logic [3:0] ea [4];
    logic [6:0] es [4];
    logic       ed [4];
    logic [3:0] an4, an5;
    logic [6:0] seg5;
    logic       lt, t3, dpn5;
    digits = 16'hFEDC; dp = 4'b0100;
    @(posedge clk); #1;
    n_checks++; if (seg !== 7'h46) begin n_fail++; $display("FAIL data_immediate_seg: got %h expected 46", seg); end
    n_checks++; if (dp_n !== 1'b1) begin n_fail++; $display("FAIL data_immediate_dpn: got %b expected 1", dp_n); end
    ea = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    es = '{7'h21, 7'h06, 7'h0E, 7'h46};
    ed = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      pulse(lt, t3, an4, an5, seg5, dpn5);
      n_checks++; if (an5 !== ea[i])  begin n_fail++; $display("FAIL hex_an[%0d]: got %b expected %b", i, an5, ea[i]); end
      n_checks++; if (seg5 !== es[i]) begin n_fail++; $display("FAIL hex_seg[%0d]: got %h expected %h", i, seg5, es[i]); end
      n_checks++; if (dpn5 !== ed[i]) begin n_fail++; $display("FAIL hex_dpn[%0d]: got %b expected %b", i, dpn5, ed[i]); end
    end
  endtask

  task automatic test_blink;
    logic [6:0] es [4];
    logic [3:0] prev_an, exp_an, an4, an5;
    logic [6:0] exp_seg, seg5;
    logic       lt, t3, dpn5;
    es = '{7'h46, 7'h21, 7'h06, 7'h0E};
    alarm = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL blink_start_visible: got %b expected 1110", an); end
    prev_an = 4'b1110;
    for (int k = 1; k <= 17; k++) begin
      if ((k % 16) >= 8) begin
        exp_an = 4'hF; exp_seg = 7'h7F;
      end else begin
        exp_an = ~(4'b0001 << (k % 4)); exp_seg = es[k % 4];
      end
      pulse(lt, t3, an4, an5, seg5, dpn5);
      n_checks++; if (an4 !== prev_an)  begin n_fail++; $display("FAIL blink_an_e4[%0d]: got %b expected %b", k, an4, prev_an); end
      n_checks++; if (an5 !== exp_an)   begin n_fail++; $display("FAIL blink_an[%0d]: got %b expected %b", k, an5, exp_an); end
      n_checks++; if (seg5 !== exp_seg) begin n_fail++; $display("FAIL blink_seg[%0d]: got %h expected %h", k, seg5, exp_seg); end
      prev_an = exp_an;
    end
    alarm = 1'b0;
  endtask

  task automatic test_enable;
    logic [3:0] an4, an5;
    logic [6:0] seg5;
    logic       lt, t3, dpn5;
    pulse(lt, t3, an4, an5, seg5, dpn5);
    n_checks++; if (an5 !== 4'b1011) begin n_fail++; $display("FAIL en_idx2: got %b expected 1011", an5); end
    enable = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (an !== 4'hF)   begin n_fail++; $display("FAIL en_off_an: got %b expected 1111", an); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL en_off_seg: got %h expected 7f", seg); end
    n_checks++; if (dp_n !== 1'b1) begin n_fail++; $display("FAIL en_off_dpn: got %b expected 1", dp_n); end
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL en_restart_an: got %b expected 1110", an); end
    n_checks++; if (seg !== 7'h46)  begin n_fail++; $display("FAIL en_restart_seg: got %h expected 46", seg); end
    pulse(lt, t3, an4, an5, seg5, dpn5);
    n_checks++; if (an5 !== 4'b1101) begin n_fail++; $display("FAIL en_idx1: got %b expected 1101", an5); end
    clkLeds = 1'b0;
    repeat (20) @(posedge clk);
    #1 clkLeds = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL en_coinc_tick: got %b expected 1", tick); end
    enable = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL en_coinc_blank: got %b expected 1111", an); end
    enable = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL en_coinc_idx0: got %b expected 1110", an); end
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midscan;
    logic [3:0] an4, an5;
    logic [6:0] seg5;
    logic       lt, t3, dpn5, saw;
    alarm = 1'b1;
    for (int k = 0; k < 11; k++) pulse(lt, t3, an4, an5, seg5, dpn5);
    n_checks++; if (an5 !== 4'hF) begin n_fail++; $display("FAIL rst_pre_blank: got %b expected 1111", an5); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (an !== 4'hF)   begin n_fail++; $display("FAIL rst_mid_an: got %b expected 1111", an); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL rst_mid_seg: got %h expected 7f", seg); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tick: got %b expected 0", tick); end
    alarm = 1'b0; digits = 16'h3210; dp = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL rst2_an: got %b expected 1110", an); end
    n_checks++; if (seg !== 7'h40)  begin n_fail++; $display("FAIL rst2_seg: got %h expected 40", seg); end
    saw = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (tick) saw = 1'b1; end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rst2_no_tick: got %b expected 0", saw); end
    pulse(lt, t3, an4, an5, seg5, dpn5);
    n_checks++; if (an5 !== 4'b1101) begin n_fail++; $display("FAIL rst2_scan_an: got %b expected 1101", an5); end
    n_checks++; if (seg5 !== 7'h79)  begin n_fail++; $display("FAIL rst2_scan_seg: got %h expected 79", seg5); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (an !== 4'hF)   begin n_fail++; $display("FAIL rst_async_an: got %b expected 1111", an); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL rst_async_seg: got %h expected 7f", seg); end
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset;
    test_scan;
    test_digits_dp;
    test_blink;
    test_enable;
    test_reset_midscan;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
